oam_dma_ctrl: RTL
=================

// Module: oam_dma_ctrl
// PURPOSE
// OAM DMA engine behind the 0xFF46 DMA register. A CPU write of XX copies 160 bytes
// from XX00-XX9F into OAM 0xFE00-0xFE9F, one byte per CLKS_PER_BYTE clocks.
// Sits beside mmu_m: slave on mmu_m's mmio_dma_if port, bus master on mmu_m's dma_req port.
// mmu_m gives the DMA priority over the CPU and blocks CPU OAM access unless dma_req.addr_select == 16'hFFFF.
// PARAMETERS
// CLKS_PER_BYTE  4    clocks per transferred byte (one M-cycle); must be >= READ_LAT+1
// READ_LAT       2    clocks source address is held before read_out is sampled
// N_BYTES        160  bytes per transfer
// PORTS
// clk        in   1   system clock; all state changes on posedge
// rst        in   1   synchronous, active-high reset
// mmio_req   mem_if.slave   addr_select[15:0], write_value[7:0], write_enable, read_out[7:0] (FF46 reg)
// dma_req    mem_if.master  addr_select[15:0], write_value[7:0], write_enable, read_out[7:0] (to mmu_m)
// busy       out  1   high while a transfer is in progress
// done       out  1   one-clock pulse after the final OAM write
// BEHAVIOUR
// - Reset: state IDLE; dma_reg=8'h00; byte_idx=0; phase=0; busy=0; done=0;
//   dma_req.addr_select=16'hFFFF, write_value=0, write_enable=0.
// - Register: mmio_req.read_out = dma_reg, combinational.
//   Start = mmio_req.write_enable rising edge (we & ~we_q) with addr_select==16'hFF46.
//   A held write_enable starts exactly once.
// - Start latches dma_reg=write_value and src_hi = (value>8'hDF) ? value-8'h20 : value.
//   Sets byte_idx=0, phase=0, busy=1. Bus is driven from the next clock.
// - States: IDLE -> XFER on start; XFER -> IDLE after byte N_BYTES-1 reaches phase CLKS_PER_BYTE-1.
// - XFER, per byte i (phase counts 0..CLKS_PER_BYTE-1, wraps, then i increments):
//   phase 0..READ_LAT-1: addr={src_hi,8'h00}+i, we=0; data_q<=read_out on phase READ_LAT-1
//   phase READ_LAT:      addr=16'hFE00+i, write_value=data_q, we=1 (exactly one clock)
//   later phases:        addr=16'hFE00+i, we=0 (never 16'hFFFF mid-transfer)
// - Index width 8 bits. src and dest address adds are 16-bit and never wrap, since max src_hi is 8'hDF.
// - End: the clock after the last phase, the FSM returns to IDLE: busy=0, done=1 for one clock, bus back to idle values.
//   Total: busy high for N_BYTES*CLKS_PER_BYTE clocks. Start at edge N -> first src addr at edge N+1.
// - Start while busy: restarts from byte 0 with the new source; no done pulse for the aborted transfer.
//   Bytes already written remain in OAM.
// - Start and last-byte completion on the same clock: the restart wins; no done pulse.
// - rst mid-transfer: returns to IDLE immediately; the addr=FFFF release is visible the clock after.
// - Writes to any address other than FF46 are ignored; dma_req.read_out is used only in read phases.
// TESTING
// 1 rst held 3 clks -> addr=FFFF, we=0, busy=0, done=0, read_out=00.
// 2 write FF46=C1; WRAM C100+i holds i^8'h5A -> OAM FE00+i holds i^8'h5A for i=0..159.
//   Exactly 160 we pulses; busy high 640 clks; done pulses once; FF46 reads C1.
// 3 write FF46=E2 -> source addresses C200..C29F; no address >= E000 issued.
// 4 restart at byte 50 with FF46=80 -> the next bus cycle reads 8000; 160 further writes; a single done pulse.
// 5 rst asserted at byte 10 -> addr=FFFF the next clock; busy=0; no done; the next FF46 write runs a full transfer.
// 6 write_enable held 5 clks at FF46 -> a single start; byte 0 is read once only.

Source files
------------

// File: rtl/oam_dma_ctrl.sv
// OAM DMA engine behind the FF46 register: copies N_BYTES from {src_hi,00} into FE00,
// one byte per CLKS_PER_BYTE clocks, mastering the bus while busy.
module oam_dma_ctrl #(
  parameter int CLKS_PER_BYTE = 4,
  parameter int READ_LAT      = 2,
  parameter int N_BYTES       = 160
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] mmio_addr_select,
  input  logic [7:0]  mmio_write_value,
  input  logic        mmio_write_enable,
  output logic [7:0]  mmio_read_out,
  output logic [15:0] dma_addr_select,
  output logic [7:0]  dma_write_value,
  output logic        dma_write_enable,
  input  logic [7:0]  dma_read_out,
  output logic        busy,
  output logic        done
);

  localparam int PH_W = (CLKS_PER_BYTE > 1) ? $clog2(CLKS_PER_BYTE) : 1;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] XFER = 1'b1;
  localparam logic [PH_W-1:0] PH_RD   = PH_W'(READ_LAT - 1);
  localparam logic [PH_W-1:0] PH_WR   = PH_W'(READ_LAT);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(CLKS_PER_BYTE - 1);
  localparam logic [7:0]      IDX_LAST = 8'(N_BYTES - 1);

  logic [0:0]      state;
  logic            we_q;
  logic [7:0]      dma_reg;
  logic [7:0]      src_hi;
  logic [7:0]      byte_idx;
  logic [PH_W-1:0] phase;
  logic [7:0]      data_q;
  logic            start;
  logic [7:0]      new_src;

  assign start   = mmio_write_enable & ~we_q & (mmio_addr_select == 16'hFF46);
  // Echo region E000-FFFF maps back onto WRAM C000-DFFF
  assign new_src = (mmio_write_value > 8'hDF) ? mmio_write_value - 8'h20 : mmio_write_value;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      we_q     <= 1'b0;
      dma_reg  <= 8'h00;
      src_hi   <= 8'h00;
      byte_idx <= 8'h00;
      phase    <= '0;
      data_q   <= 8'h00;
      done     <= 1'b0;
    end else begin
      we_q <= mmio_write_enable;
      done <= 1'b0;
      // A start always wins, including over completion of the last byte
      if (start) begin
        dma_reg  <= mmio_write_value;
        src_hi   <= new_src;
        byte_idx <= 8'h00;
        phase    <= '0;
        state    <= XFER;
      end else if (state == XFER) begin
        if (phase == PH_RD) data_q <= dma_read_out;
        if (phase == PH_LAST) begin
          phase <= '0;
          if (byte_idx == IDX_LAST) begin
            state    <= IDLE;
            done     <= 1'b1;
            byte_idx <= 8'h00;
          end else begin
            byte_idx <= byte_idx + 8'h01;
          end
        end else begin
          phase <= phase + 1'b1;
        end
      end
    end
  end

  // Bus holds the destination after the write so the CPU never slips in mid-byte
  always_comb begin
    dma_addr_select  = 16'hFFFF;
    dma_write_value  = 8'h00;
    dma_write_enable = 1'b0;
    if (state == XFER) begin
      if (phase < PH_WR) begin
        dma_addr_select = {src_hi, 8'h00} + {8'h00, byte_idx};
      end else begin
        dma_addr_select = 16'hFE00 + {8'h00, byte_idx};
        if (phase == PH_WR) begin
          dma_write_value  = data_q;
          dma_write_enable = 1'b1;
        end
      end
    end
  end

  assign busy          = (state == XFER);
  assign mmio_read_out = dma_reg;

endmodule
